bpu_btb_predictor: RTL and testbench

- Branch prediction unit that drives the fetch-PC / ground-truth feedback interface from the initiator side.
- Issues one fetch PC at a time and makes a prediction from a direct-mapped BTB with 2-bit saturating counters.
- Consumes the ground-truth feedback, trains the BTB and redirects on misprediction.
- Sits in the IFU in place of the fetch sequencer. Exposes prediction statistics for the test harness.

---
 rtl/bpu_btb_predictor.sv | 157 +++++++++++++++
 tb/tb_bpu_btb_predictor.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_btb_predictor.sv
// Branch prediction unit: issues one fetch PC at a time, predicts it from a
// direct-mapped BTB with 2-bit saturating counters, then trains/redirects on feedback.
module bpu_btb_predictor #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          IDX_W       = 4,
  parameter int          FB_TIMEOUT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] bpu_fetch_pc,
  output logic        bpu_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        actual_is_branch,
  input  logic        actual_taken,
  input  logic [31:0] actual_target_pc,
  input  logic        feedback_valid,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count,
  output logic [15:0] timeout_count
);

  localparam int TAG_W  = 32 - IDX_W - 2;
  localparam int WCNT_W = (FB_TIMEOUT > 1) ? $clog2(FB_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FB_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t            state;
  logic [31:0]       pc;
  logic [31:0]       fetch_pc_q;
  logic [31:0]       pred_target_q;
  logic              pred_hit_q;
  logic [WCNT_W-1:0] wait_cnt;

  logic              btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
  logic [31:0]       btb_target [BTB_ENTRIES];
  logic [1:0]        btb_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [31:0]       pc_plus4;
  logic              lookup_hit;
  logic              lookup_taken;
  logic [31:0]       lookup_target;
  logic              in_issue;
  logic              resolve;
  logic [31:0]       correct_pc;

  assign idx           = pc[IDX_W+1:2];
  assign tag           = pc[31:IDX_W+2];
  assign pc_plus4      = pc + 32'd4;
  assign lookup_hit    = btb_valid[idx] && (btb_tag[idx] == tag);
  assign lookup_taken  = lookup_hit && btb_ctr[idx][1];
  assign lookup_target = lookup_taken ? btb_target[idx] : pc_plus4;

  assign in_issue   = (state == ST_ISSUE);
  assign resolve    = (state == ST_WAIT) && feedback_valid;
  assign correct_pc = (actual_is_branch && actual_taken) ? actual_target_pc : pc_plus4;

  // The lookup reads the table during ISSUE itself, so a write made on the
  // resolving edge is already visible to a back-to-back issue of the same PC.
  assign bpu_valid    = in_issue;
  assign pred_taken   = in_issue && lookup_taken;
  assign pred_target  = in_issue ? lookup_target : 32'd0;
  assign bpu_fetch_pc = in_issue ? pc : fetch_pc_q;
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      pc               <= RESET_PC;
      fetch_pc_q       <= 32'd0;
      pred_target_q    <= 32'd0;
      pred_hit_q       <= 1'b0;
      wait_cnt         <= '0;
      mispredict       <= 1'b0;
      redirect_pc      <= 32'd0;
      branch_count     <= 16'd0;
      mispredict_count <= 16'd0;
      timeout_count    <= 16'd0;
    end else begin
      mispredict <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          fetch_pc_q    <= pc;
          pred_target_q <= lookup_target;
          pred_hit_q    <= lookup_hit;
          wait_cnt      <= '0;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          // Feedback arriving on the last allowed cycle still wins over the timeout.
          if (feedback_valid) begin
            if (correct_pc != pred_target_q) begin
              mispredict       <= 1'b1;
              redirect_pc      <= correct_pc;
              mispredict_count <= mispredict_count + 16'd1;
            end
            if (actual_is_branch) branch_count <= branch_count + 16'd1;
            pc    <= correct_pc;
            state <= enable ? ST_ISSUE : ST_IDLE;
          end else if (wait_cnt == WCNT_LAST) begin
            pc            <= pc_plus4;
            timeout_count <= timeout_count + 16'd1;
            state         <= enable ? ST_ISSUE : ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Training uses the hit latched at issue; pc is stable through WAIT so idx/tag still apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= 32'd0;
        btb_ctr[i]    <= 2'b00;
      end
    end else if (resolve) begin
      if (actual_is_branch) begin
        btb_target[idx] <= actual_target_pc;
        if (pred_hit_q) begin
          if (actual_taken && (btb_ctr[idx] != 2'b11))
            btb_ctr[idx] <= btb_ctr[idx] + 2'b01;
          else if (!actual_taken && (btb_ctr[idx] != 2'b00))
            btb_ctr[idx] <= btb_ctr[idx] - 2'b01;
        end else begin
          btb_valid[idx] <= 1'b1;
          btb_tag[idx]   <= tag;
          btb_ctr[idx]   <= actual_taken ? 2'b10 : 2'b01;
        end
      end else if (pred_hit_q) begin
        btb_valid[idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bpu_btb_predictor.sv
// Bench for bpu_btb_predictor: directed vector table, timeout/reset sequences,
// then random transactions checked against a behavioural BTB model.
module tb_bpu_btb_predictor;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          ENTRIES    = 16;
  localparam int          IDX_W      = 4;
  localparam int          FB_TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] bpu_fetch_pc;
  logic        bpu_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        actual_is_branch;
  logic        actual_taken;
  logic [31:0] actual_target_pc;
  logic        feedback_valid;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;
  logic [15:0] timeout_count;

  bpu_btb_predictor #(
    .RESET_PC   (RESET_PC),
    .BTB_ENTRIES(ENTRIES),
    .IDX_W      (IDX_W),
    .FB_TIMEOUT (FB_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .bpu_fetch_pc    (bpu_fetch_pc),
    .bpu_valid       (bpu_valid),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .actual_is_branch(actual_is_branch),
    .actual_taken    (actual_taken),
    .actual_target_pc(actual_target_pc),
    .feedback_valid  (feedback_valid),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .busy            (busy),
    .branch_count    (branch_count),
    .mispredict_count(mispredict_count),
    .timeout_count   (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          isBr;
    bit          taken;
    logic [31:0] target;
    int          delay;
    logic [31:0] expPc;
    bit          expPredTaken;
    logic [31:0] expPredTarget;
    bit          expMis;
    logic [31:0] expRedirect;
  } vec_t;

  typedef struct {
    bit          valid;
    int unsigned tag;
    logic [31:0] target;
    int          ctr;
  } mentry_t;

  int nChecks = 0;
  int nFail   = 0;

  // Behavioural reference: table of entries plus architectural PC and statistics.
  mentry_t     mBtb [ENTRIES];
  logic [31:0] mPc;
  logic [15:0] mBranch, mMis, mTimeout;

  vec_t tbl [22];
  vec_t postTbl [3];

  function automatic vec_t mkVec(bit isBr, bit taken, logic [31:0] target, int delay,
                                 logic [31:0] expPc, bit expPt, logic [31:0] expPtgt,
                                 bit expMis, logic [31:0] expRedir);
    vec_t v;
    v.isBr = isBr; v.taken = taken; v.target = target; v.delay = delay;
    v.expPc = expPc; v.expPredTaken = expPt; v.expPredTarget = expPtgt;
    v.expMis = expMis; v.expRedirect = expRedir;
    return v;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mBtb[i].valid = 1'b0; mBtb[i].tag = 0; mBtb[i].target = 32'd0; mBtb[i].ctr = 0;
    end
    mPc = RESET_PC; mBranch = 16'd0; mMis = 16'd0; mTimeout = 16'd0;
  endfunction

  function automatic void modelPredict(input logic [31:0] pc, output bit hit,
                                       output bit tk, output logic [31:0] tgt);
    int unsigned slot = (pc / 4) % ENTRIES;
    int unsigned t    = pc / (4 * ENTRIES);
    hit = mBtb[slot].valid && (mBtb[slot].tag == t);
    tk  = hit && (mBtb[slot].ctr >= 2);
    tgt = tk ? mBtb[slot].target : pc + 32'd4;
  endfunction

  function automatic vec_t modelExpect(bit isBr, bit taken, logic [31:0] target, int delay);
    bit hit, tk;
    logic [31:0] tgt, correct;
    modelPredict(mPc, hit, tk, tgt);
    correct = (isBr && taken) ? target : mPc + 32'd4;
    return mkVec(isBr, taken, target, delay, mPc, tk, tgt, correct != tgt, correct);
  endfunction

  function automatic void modelResolve(bit isBr, bit taken, logic [31:0] target);
    bit hit, tk;
    logic [31:0] tgt, correct;
    int unsigned slot = (mPc / 4) % ENTRIES;
    modelPredict(mPc, hit, tk, tgt);
    correct = (isBr && taken) ? target : mPc + 32'd4;
    if (correct != tgt) mMis = mMis + 16'd1;
    if (isBr) begin
      mBranch = mBranch + 16'd1;
      mBtb[slot].target = target;
      if (hit) begin
        if (taken) mBtb[slot].ctr = (mBtb[slot].ctr < 3) ? mBtb[slot].ctr + 1 : 3;
        else       mBtb[slot].ctr = (mBtb[slot].ctr > 0) ? mBtb[slot].ctr - 1 : 0;
      end else begin
        mBtb[slot].valid = 1'b1;
        mBtb[slot].tag   = mPc / (4 * ENTRIES);
        mBtb[slot].ctr   = taken ? 2 : 1;
      end
    end else if (hit) begin
      mBtb[slot].valid = 1'b0;
    end
    mPc = correct;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkCounters();
    checkOutput("branch_count", 32'(branch_count), 32'(mBranch));
    checkOutput("mispredict_count", 32'(mispredict_count), 32'(mMis));
    checkOutput("timeout_count", 32'(timeout_count), 32'(mTimeout));
  endtask

  task automatic waitIssue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bpu_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    nChecks++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL issue_wait: no bpu_valid within 6 cycles, expected pc 0x%08h", mPc);
    end
  endtask

  task automatic applyStimulus(input bit isBr, input bit taken, input logic [31:0] target, input int delay);
    repeat (delay) @(negedge clk);
    feedback_valid   = 1'b1;
    actual_is_branch = isBr;
    actual_taken     = taken;
    actual_target_pc = target;
    @(negedge clk);
    feedback_valid   = 1'b0;
    actual_is_branch = 1'b0;
    actual_taken     = 1'b0;
    actual_target_pc = 32'd0;
  endtask

  task automatic doTxn(input vec_t v, input bit noise, input bit dropEnable);
    bit ok;
    logic [31:0] correct;
    waitIssue(ok);
    if (!ok) return;
    checkOutput("fetch_pc", bpu_fetch_pc, v.expPc);
    checkOutput("pred_taken", 32'(pred_taken), 32'(v.expPredTaken));
    checkOutput("pred_target", pred_target, v.expPredTarget);
    if (noise) begin
      feedback_valid = 1'b1; actual_is_branch = 1'b1;
      actual_taken = 1'b1; actual_target_pc = 32'hDEAD_BEE0;
    end
    @(negedge clk);
    feedback_valid = 1'b0; actual_is_branch = 1'b0; actual_taken = 1'b0;
    checkOutput("wait_busy", 32'(busy), 32'd1);
    if (dropEnable) enable = 1'b0;
    applyStimulus(v.isBr, v.taken, v.target, v.delay);
    modelResolve(v.isBr, v.taken, v.target);
    checkOutput("mispredict", 32'(mispredict), 32'(v.expMis));
    if (v.expMis) checkOutput("redirect_pc", redirect_pc, v.expRedirect);
    checkCounters();
    correct = (v.isBr && v.taken) ? v.target : v.expPc + 32'd4;
    if (dropEnable) begin
      checkOutput("idle_after_drop", 32'({busy, bpu_valid}), 32'd0);
      enable = 1'b1;
    end else begin
      checkOutput("next_issue_valid", 32'(bpu_valid), 32'd1);
      checkOutput("next_issue_pc", bpu_fetch_pc, correct);
    end
  endtask

  task automatic doTimeout(input logic [31:0] expPc, input logic [31:0] expPredTarget);
    bit ok;
    waitIssue(ok);
    if (!ok) return;
    checkOutput("to_fetch_pc", bpu_fetch_pc, expPc);
    checkOutput("to_pred_target", pred_target, expPredTarget);
    repeat (FB_TIMEOUT) @(negedge clk);
    checkOutput("to_still_waiting", 32'({busy, bpu_valid}), 32'b10);
    @(negedge clk);
    mPc = mPc + 32'd4;
    mTimeout = mTimeout + 16'd1;
    checkOutput("to_mispredict", 32'(mispredict), 32'd0);
    checkCounters();
    checkOutput("to_next_valid", 32'(bpu_valid), 32'd1);
    checkOutput("to_next_pc", bpu_fetch_pc, expPc + 32'd4);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit hit, tk, isBr, taken, noise, drop;
    logic [31:0] tgt;
    vec_t v;

    // isBr, taken, target, delay | pc, predTaken, predTarget, mispredict, redirect
    tbl[0]  = mkVec(0, 0, 32'h00, 0, 32'h00, 0, 32'h04, 0, 32'h00);
    tbl[1]  = mkVec(0, 0, 32'h00, 1, 32'h04, 0, 32'h08, 0, 32'h00);
    tbl[2]  = mkVec(0, 0, 32'h00, 3, 32'h08, 0, 32'h0C, 0, 32'h00);
    tbl[3]  = mkVec(0, 0, 32'h00, 0, 32'h0C, 0, 32'h10, 0, 32'h00);
    tbl[4]  = mkVec(1, 1, 32'h40, 0, 32'h10, 0, 32'h14, 1, 32'h40);
    tbl[5]  = mkVec(1, 1, 32'h10, 0, 32'h40, 0, 32'h44, 1, 32'h10);
    tbl[6]  = mkVec(1, 0, 32'h40, 2, 32'h10, 1, 32'h40, 1, 32'h14);
    tbl[7]  = mkVec(1, 1, 32'h10, 0, 32'h14, 0, 32'h18, 1, 32'h10);
    tbl[8]  = mkVec(1, 1, 32'h40, 0, 32'h10, 0, 32'h14, 1, 32'h40);
    tbl[9]  = mkVec(1, 1, 32'h10, 1, 32'h40, 1, 32'h10, 0, 32'h00);
    tbl[10] = mkVec(1, 0, 32'h40, 0, 32'h10, 1, 32'h40, 1, 32'h14);
    tbl[11] = mkVec(1, 1, 32'h10, 0, 32'h14, 1, 32'h10, 0, 32'h00);
    tbl[12] = mkVec(1, 1, 32'h40, 3, 32'h10, 0, 32'h14, 1, 32'h40);
    tbl[13] = mkVec(1, 1, 32'h50, 0, 32'h40, 1, 32'h10, 1, 32'h50);
    tbl[14] = mkVec(0, 0, 32'h00, 2, 32'h50, 0, 32'h54, 0, 32'h00);
    tbl[15] = mkVec(1, 1, 32'h10, 0, 32'h54, 0, 32'h58, 1, 32'h10);
    tbl[16] = mkVec(0, 0, 32'h00, 0, 32'h10, 1, 32'h40, 1, 32'h14);
    tbl[17] = mkVec(1, 1, 32'h10, 1, 32'h14, 0, 32'h18, 1, 32'h10);
    tbl[18] = mkVec(0, 0, 32'h00, 0, 32'h10, 0, 32'h14, 0, 32'h00);
    tbl[19] = mkVec(0, 0, 32'h00, 0, 32'h14, 1, 32'h10, 1, 32'h18);
    tbl[20] = mkVec(0, 0, 32'h00, 0, 32'h18, 0, 32'h1C, 0, 32'h00);
    tbl[21] = mkVec(0, 0, 32'h00, 0, 32'h1C, 0, 32'h20, 0, 32'h00);
    postTbl[0] = mkVec(0, 0, 32'h00, 0, 32'h00, 0, 32'h04, 0, 32'h00);
    postTbl[1] = mkVec(1, 1, 32'h40, 0, 32'h04, 0, 32'h08, 1, 32'h40);
    postTbl[2] = mkVec(0, 0, 32'h00, 0, 32'h40, 0, 32'h44, 0, 32'h00);

    rst = 1'b1; enable = 1'b0; feedback_valid = 1'b0;
    actual_is_branch = 1'b0; actual_taken = 1'b0; actual_target_pc = 32'd0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(bpu_valid), 32'd0);
    checkOutput("rst_fetch_pc", bpu_fetch_pc, 32'd0);
    checkOutput("rst_pred", 32'(pred_taken) | pred_target, 32'd0);
    checkOutput("rst_mispredict", 32'(mispredict) | redirect_pc, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkCounters();

    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 22; i++) doTxn(tbl[i], 1'b0, 1'b0);

    doTimeout(32'h20, 32'h24);
    checkOutput("after_to_pred_target", pred_target, 32'h28);

    // Reset in WAIT with feedback presented at the same edge: reset must win.
    @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    feedback_valid = 1'b1; actual_is_branch = 1'b1; actual_taken = 1'b1; actual_target_pc = 32'h40;
    @(negedge clk);
    feedback_valid = 1'b0; actual_is_branch = 1'b0; actual_taken = 1'b0; actual_target_pc = 32'd0;
    modelReset();
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_outputs", 32'(bpu_valid) | bpu_fetch_pc | pred_target | 32'(mispredict) | redirect_pc, 32'd0);
    checkCounters();
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) doTxn(postTbl[i], 1'b0, 1'b0);

    for (int n = 0; n < 90; n++) begin
      if ($urandom_range(0, 99) < 8) begin
        modelPredict(mPc, hit, tk, tgt);
        doTimeout(mPc, tgt);
      end else begin
        isBr  = 1'($urandom_range(0, 1));
        taken = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFFC;
        else tgt = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        noise = ($urandom_range(0, 9) == 0);
        drop  = ($urandom_range(0, 9) == 0);
        v = modelExpect(isBr, taken, tgt, int'($urandom_range(0, 3)));
        doTxn(v, noise, drop);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
